// File: rtl/mem_stage_pipe_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage_pipe_if
// Brief   : EX/MEM -> MEM/WB bundle for the memory-access pipeline stage.
//           The master is the EX/MEM side; the slave is the MEM stage itself.
// Revision: 1.0  initial release
// ============================================================================
interface mem_stage_pipe_if #(
  parameter int REG_W = 5
);
  // EX/MEM side
  logic             in_valid;
  logic             in_ready;
  logic             mem_read;
  logic             mem_write;
  logic [1:0]       mem_size;
  logic             mem_unsigned;
  logic [1:0]       branch_op;
  logic             zero;
  logic [31:0]      alu_out;
  logic [31:0]      store_data;
  logic             wb_memtoreg;
  logic             wb_regwrite;
  logic [REG_W-1:0] rd;
  // Branch resolution and MEM/WB side
  logic             pcsrc;
  logic             out_valid;
  logic             out_memtoreg;
  logic             out_regwrite;
  logic [REG_W-1:0] out_rd;
  logic [31:0]      out_aluout;
  logic [31:0]      out_rdata;
  logic             out_misalign;

  modport master (
    output in_valid, mem_read, mem_write, mem_size, mem_unsigned, branch_op,
           zero, alu_out, store_data, wb_memtoreg, wb_regwrite, rd,
    input  in_ready, pcsrc, out_valid, out_memtoreg, out_regwrite, out_rd,
           out_aluout, out_rdata, out_misalign
  );

  modport slave (
    input  in_valid, mem_read, mem_write, mem_size, mem_unsigned, branch_op,
           zero, alu_out, store_data, wb_memtoreg, wb_regwrite, rd,
    output in_ready, pcsrc, out_valid, out_memtoreg, out_regwrite, out_rd,
           out_aluout, out_rdata, out_misalign
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage_pipe
// Brief   : MEM stage of the 5-stage core: branch resolution, byte/half/word
//           stores and extended loads on an internal synchronous RAM, and the
//           MEM/WB register. Aligned loads take two cycles and stall EX/MEM.
// Revision: 1.0  initial release
// ============================================================================
module mem_stage_pipe #(
  parameter int DEPTH = 256,
  parameter int REG_W = 5
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  mem_stage_pipe_if.slave   mem_if
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [0:0] {
    RUN       = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  state_t           state_q;

  // Load context parked while the RAM read completes
  logic             ld_m2r_q;
  logic             ld_rw_q;
  logic [REG_W-1:0] ld_rd_q;
  logic [31:0]      ld_alu_q;
  logic [1:0]       ld_size_q;
  logic             ld_uns_q;

  // MEM/WB register
  logic             out_valid_q;
  logic             out_m2r_q;
  logic             out_rw_q;
  logic [REG_W-1:0] out_rd_q;
  logic [31:0]      out_alu_q;
  logic [31:0]      out_rdata_q;
  logic             out_mis_q;

  logic [31:0]      ram_q [DEPTH];
  logic [31:0]      rdata_q;

  logic             w_run;
  logic             w_accept;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_lane;
  logic             w_unaligned;
  logic             w_mis_access;
  logic             w_st_go;
  logic             w_ld_go;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [7:0]       w_byte_sel;
  logic [15:0]      w_half_sel;
  logic [31:0]      w_ld_ext;

  assign w_run    = (state_q == RUN);
  assign w_accept = mem_if.in_valid & w_run;
  // Upper address bits are dropped so the RAM aliases every 4*DEPTH bytes
  assign w_idx    = mem_if.alu_out[IDX_W+1:2];
  assign w_lane   = mem_if.alu_out[1:0];

  // Alignment check by access size; bytes can never be misaligned
  always_comb begin
    w_unaligned = 1'b0;
    case (mem_if.mem_size)
      2'b00:   w_unaligned = 1'b0;
      2'b01:   w_unaligned = w_lane[0];
      default: w_unaligned = |w_lane;
    endcase
  end

  assign w_mis_access = (mem_if.mem_read | mem_if.mem_write) & w_unaligned;
  // A set mem_write wins over mem_read: both high is a store
  assign w_st_go = w_accept & mem_if.mem_write & ~w_unaligned;
  assign w_ld_go = w_accept & mem_if.mem_read & ~mem_if.mem_write & ~w_unaligned;

  // Byte enables and lane-replicated write data for sub-word stores
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = mem_if.store_data;
    case (mem_if.mem_size)
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{mem_if.store_data[7:0]}};
      end
      2'b01: begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{mem_if.store_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = mem_if.store_data;
      end
    endcase
  end

  // Data RAM: byte-enable write and registered read, both on the accept edge
  always_ff @(posedge clk) begin
    if (w_st_go) begin
      for (int l = 0; l < 4; l++) begin
        if (w_be[l]) ram_q[w_idx][8*l +: 8] <= w_wdata[8*l +: 8];
      end
    end
    if (w_ld_go) rdata_q <= ram_q[w_idx];
  end

  // Move the addressed byte/half of the read word to bit 0 and extend it
  always_comb begin
    case (ld_alu_q[1:0])
      2'd0:    w_byte_sel = rdata_q[7:0];
      2'd1:    w_byte_sel = rdata_q[15:8];
      2'd2:    w_byte_sel = rdata_q[23:16];
      default: w_byte_sel = rdata_q[31:24];
    endcase
    w_half_sel = ld_alu_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (ld_size_q)
      2'b00:   w_ld_ext = ld_uns_q ? {24'd0, w_byte_sel}
                                   : {{24{w_byte_sel[7]}}, w_byte_sel};
      2'b01:   w_ld_ext = ld_uns_q ? {16'd0, w_half_sel}
                                   : {{16{w_half_sel[15]}}, w_half_sel};
      default: w_ld_ext = rdata_q;
    endcase
  end

  // Stage FSM, load context capture and MEM/WB register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      ld_m2r_q    <= 1'b0;
      ld_rw_q     <= 1'b0;
      ld_rd_q     <= '0;
      ld_alu_q    <= '0;
      ld_size_q   <= 2'b00;
      ld_uns_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_m2r_q   <= 1'b0;
      out_rw_q    <= 1'b0;
      out_rd_q    <= '0;
      out_alu_q   <= '0;
      out_rdata_q <= '0;
      out_mis_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (w_ld_go) begin
            state_q   <= LOAD_WAIT;
            ld_m2r_q  <= mem_if.wb_memtoreg;
            ld_rw_q   <= mem_if.wb_regwrite;
            ld_rd_q   <= mem_if.rd;
            ld_alu_q  <= mem_if.alu_out;
            ld_size_q <= mem_if.mem_size;
            ld_uns_q  <= mem_if.mem_unsigned;
          end else if (w_accept) begin
            out_valid_q <= 1'b1;
            out_m2r_q   <= mem_if.wb_memtoreg;
            out_rw_q    <= mem_if.wb_regwrite & ~w_mis_access;
            out_rd_q    <= mem_if.rd;
            out_alu_q   <= mem_if.alu_out;
            out_rdata_q <= '0;
            out_mis_q   <= w_mis_access;
          end
        end
        LOAD_WAIT: begin
          state_q     <= RUN;
          out_valid_q <= 1'b1;
          out_m2r_q   <= ld_m2r_q;
          out_rw_q    <= ld_rw_q;
          out_rd_q    <= ld_rd_q;
          out_alu_q   <= ld_alu_q;
          out_rdata_q <= w_ld_ext;
          out_mis_q   <= 1'b0;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign mem_if.in_ready     = w_run;
  assign mem_if.pcsrc        = w_accept &
                               ((mem_if.branch_op == 2'b01 &  mem_if.zero) |
                                (mem_if.branch_op == 2'b10 & ~mem_if.zero) |
                                (mem_if.branch_op == 2'b11));
  assign mem_if.out_valid    = out_valid_q;
  assign mem_if.out_memtoreg = out_m2r_q;
  assign mem_if.out_regwrite = out_rw_q;
  assign mem_if.out_rd       = out_rd_q;
  assign mem_if.out_aluout   = out_alu_q;
  assign mem_if.out_rdata    = out_rdata_q;
  assign mem_if.out_misalign = out_mis_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_stage_pipe
// Brief   : Self-checking bench for mem_stage_pipe: directed cases with
//           literal expectations plus randomized traffic against a
//           byte-array memory model with a per-cycle expected-output schedule.
// Revision: 1.0  initial release
// ============================================================================
module tb_mem_stage_pipe;

  localparam int DEPTH  = 256;
  localparam int REG_W  = 5;
  localparam int MAXC   = 8000;
  localparam int NBYTES = 4 * DEPTH;

  typedef struct packed {
    logic             v;
    logic             m2r;
    logic             rw;
    logic [REG_W-1:0] rd;
    logic [31:0]      alu;
    logic [31:0]      rdata;
    logic             mis;
  } wb_t;

  typedef struct packed {
    logic             valid;
    logic             mrd;
    logic             mwr;
    logic [1:0]       size;
    logic             uns;
    logic [1:0]       bop;
    logic             zero;
    logic [31:0]      alu;
    logic [31:0]      sd;
    logic             m2r;
    logic             rw;
    logic [REG_W-1:0] rdi;
  } ins_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_stage_pipe_if #(.REG_W(REG_W)) bus();

  mem_stage_pipe #(.DEPTH(DEPTH), .REG_W(REG_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mem_if (bus)
  );

  // Model state: byte-addressed memory and a per-cycle expected schedule
  logic [7:0] mem_m [NBYTES];
  wb_t        sched [MAXC];
  bit         sched_v [MAXC];
  bit         reset_cyc [MAXC];
  bit         exp_nready [MAXC];
  bit         exp_pcsrc [MAXC];
  wb_t        cur;
  int         cyc = 0;
  int         busy_cyc = -1;
  bit         last_acc;
  bit         done = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= MAXC - 4) begin
      $display("FAIL cycle_budget cycle %0d: got %0d expected < %0d", cyc, cyc, MAXC - 4);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  // Executes one accepted instruction on the model and schedules its result
  task automatic model_exec(input ins_t i);
    int          a;
    int          nb;
    logic [31:0] v;
    wb_t         r;
    bit          mis;
    a   = int'(i.alu % 32'(NBYTES));
    nb  = (i.size == 2'd0) ? 1 : (i.size == 2'd1) ? 2 : 4;
    mis = (i.mrd || i.mwr) && (a % nb != 0);
    r.v     = 1'b1;
    r.m2r   = i.m2r;
    r.rw    = i.rw && !mis;
    r.rd    = i.rdi;
    r.alu   = i.alu;
    r.rdata = 32'd0;
    r.mis   = mis;
    if (!mis && i.mwr) begin
      for (int k = 0; k < nb; k++) mem_m[a + k] = i.sd[8*k +: 8];
      sched[cyc + 1] = r;  sched_v[cyc + 1] = 1'b1;
    end else if (!mis && i.mrd) begin
      v = 32'd0;
      for (int k = 0; k < nb; k++) v = v | (32'(mem_m[a + k]) << (8 * k));
      if (!i.uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
      r.rdata = v;
      sched[cyc + 2] = r;  sched_v[cyc + 2] = 1'b1;
      busy_cyc = cyc + 1;
    end else begin
      sched[cyc + 1] = r;  sched_v[cyc + 1] = 1'b1;
    end
  endtask

  // Drives one cycle of inputs and records what the stage must do with them
  task automatic apply(input ins_t i);
    bit rdy;
    bus.in_valid     = i.valid;
    bus.mem_read     = i.mrd;
    bus.mem_write    = i.mwr;
    bus.mem_size     = i.size;
    bus.mem_unsigned = i.uns;
    bus.branch_op    = i.bop;
    bus.zero         = i.zero;
    bus.alu_out      = i.alu;
    bus.store_data   = i.sd;
    bus.wb_memtoreg  = i.m2r;
    bus.wb_regwrite  = i.rw;
    bus.rd           = i.rdi;
    rdy = (busy_cyc != cyc);
    exp_nready[cyc] = !rdy;
    last_acc = i.valid && rdy;
    exp_pcsrc[cyc] = last_acc && ((i.bop == 2'd1 && i.zero) ||
                                  (i.bop == 2'd2 && !i.zero) || (i.bop == 2'd3));
    if (last_acc) model_exec(i);
  endtask

  // Presents an instruction and holds it until accepted; stays in that cycle
  task automatic issue(input ins_t i);
    apply(i);
    for (int t = 0; t < 4 && !last_acc; t++) begin
      step();
      apply(i);
    end
  endtask

  task automatic run(input ins_t i);
    issue(i);
    step();
  endtask

  function automatic ins_t mk(input bit valid, input bit rd, input bit wr,
                              input logic [1:0] sz, input bit uns,
                              input logic [1:0] bop, input bit z,
                              input logic [31:0] alu, input logic [31:0] sd);
    ins_t i;
    i.valid = valid;  i.mrd = rd;  i.mwr = wr;  i.size = sz;  i.uns = uns;
    i.bop = bop;  i.zero = z;  i.alu = alu;  i.sd = sd;
    i.m2r = rd;  i.rw = 1'b1;  i.rdi = 5'd7;
    return i;
  endfunction

  function automatic ins_t rnd_ins(input bit valid);
    ins_t i;
    int   k;
    k = int'($urandom_range(0, 3));
    i.valid = valid;
    i.mrd   = (k == 2) || (k == 3);
    i.mwr   = (k == 1) || (k == 3);
    i.size  = 2'($urandom_range(0, 3));
    i.uns   = 1'($urandom_range(0, 1));
    i.bop   = 2'($urandom_range(0, 3));
    i.zero  = 1'($urandom_range(0, 1));
    // Sixteen pre-initialised words, random upper bits to exercise aliasing
    i.alu   = ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 15)) << 2);
    i.sd    = $urandom;
    i.m2r   = 1'($urandom_range(0, 1));
    i.rw    = 1'($urandom_range(0, 1));
    i.rdi   = REG_W'($urandom);
    return i;
  endfunction

  task automatic load_lit(input string name, input logic [31:0] alu,
                          input logic [1:0] sz, input bit uns, input logic [31:0] expv);
    run(mk(1'b1, 1'b1, 1'b0, sz, uns, 2'd0, 1'b0, alu, 32'd0));
    chk({name, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({name, "_early_valid"}, 32'(bus.out_valid), 32'd0);
    apply(rnd_ins(1'b0));
    step();
    chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk(name, bus.out_rdata, expv);
  endtask

  task automatic branch_lit(input string name, input bit valid,
                            input logic [1:0] bop, input bit z, input bit expv);
    apply(mk(valid, 1'b0, 1'b0, 2'd2, 1'b0, bop, z, 32'h0000_0040, 32'd0));
    #1;
    chk(name, 32'(bus.pcsrc), 32'(expv));
    step();
  endtask

  // Per-cycle comparison of every DUT output against the model schedule
  always @(negedge clk) begin
    if (!done && cyc > 0 && cyc < MAXC) begin
      if (reset_cyc[cyc])     cur = '0;
      else if (sched_v[cyc])  cur = sched[cyc];
      else                    cur.v = 1'b0;
      chk("in_ready",     32'(bus.in_ready),     32'(!exp_nready[cyc]));
      chk("pcsrc",        32'(bus.pcsrc),        32'(exp_pcsrc[cyc]));
      chk("out_valid",    32'(bus.out_valid),    32'(cur.v));
      chk("out_memtoreg", 32'(bus.out_memtoreg), 32'(cur.m2r));
      chk("out_regwrite", 32'(bus.out_regwrite), 32'(cur.rw));
      chk("out_rd",       32'(bus.out_rd),       32'(cur.rd));
      chk("out_aluout",   bus.out_aluout,        cur.alu);
      chk("out_rdata",    bus.out_rdata,         cur.rdata);
      chk("out_misalign", 32'(bus.out_misalign), 32'(cur.mis));
    end
  end

  initial begin
    // Reset for two edges, released mid-cycle
    rst_n = 1'b0;
    reset_cyc[0] = 1'b1;
    apply(rnd_ins(1'b0));
    step();
    reset_cyc[1] = 1'b1;
    apply(rnd_ins(1'b0));
    step();
    reset_cyc[2] = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      apply(rnd_ins(1'b0));
      step();
    end
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_rdata", bus.out_rdata, 32'd0);

    // Give the sixteen words used by the traffic a defined value
    for (int w = 0; w < 16; w++)
      run(mk(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 32'(w) << 2, $urandom));

    // Word store, byte overwrite, then loads of every width
    run(mk(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 32'h10, 32'hDEAD_BEEF));
    run(mk(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 32'h12, 32'hAABB_CC55));
    load_lit("ld_word_10", 32'h10, 2'd2, 1'b0, 32'hDE55_BEEF);
    load_lit("ld_byte_13_s", 32'h13, 2'd0, 1'b0, 32'hFFFF_FFDE);
    load_lit("ld_byte_13_u", 32'h13, 2'd0, 1'b1, 32'h0000_00DE);
    load_lit("ld_half_12_s", 32'h12, 2'd1, 1'b0, 32'hFFFF_DE55);

    // Misaligned half store: flagged, latency 1, memory untouched
    run(mk(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 32'h11, 32'h0000_1234));
    chk("mis_valid", 32'(bus.out_valid), 32'd1);
    chk("mis_flag", 32'(bus.out_misalign), 32'd1);
    chk("mis_regwrite", 32'(bus.out_regwrite), 32'd0);
    chk("mis_in_ready", 32'(bus.in_ready), 32'd1);
    load_lit("ld_after_mis", 32'h10, 2'd2, 1'b0, 32'hDE55_BEEF);

    // Branch resolution
    branch_lit("beq_z1", 1'b1, 2'd1, 1'b1, 1'b1);
    branch_lit("bne_z1", 1'b1, 2'd2, 1'b1, 1'b0);
    branch_lit("bne_z0", 1'b1, 2'd2, 1'b0, 1'b1);
    branch_lit("bal",    1'b1, 2'd3, 1'b0, 1'b1);
    branch_lit("beq_iv", 1'b0, 2'd1, 1'b1, 1'b0);
    branch_lit("bne_iv", 1'b0, 2'd2, 1'b0, 1'b0);
    branch_lit("bal_iv", 1'b0, 2'd3, 1'b0, 1'b0);

    // Address wrap modulo 4*DEPTH bytes
    run(mk(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 32'h400, 32'h1234_5678));
    load_lit("wrap", 32'h0, 2'd2, 1'b0, 32'h1234_5678);

    // Reset during LOAD_WAIT discards the load
    run(mk(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0, 32'h10, 32'd0));
    rst_n = 1'b0;
    busy_cyc = -1;
    reset_cyc[cyc] = 1'b1;
    for (int k = 0; k < 4; k++) sched_v[cyc + k] = 1'b0;
    apply(rnd_ins(1'b0));
    step();
    reset_cyc[cyc] = 1'b1;
    rst_n = 1'b1;
    apply(rnd_ins(1'b0));
    #1;
    chk("rst_lw_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_lw_valid0", 32'(bus.out_valid), 32'd0);
    step();
    chk("rst_lw_valid1", 32'(bus.out_valid), 32'd0);
    apply(rnd_ins(1'b0));
    step();

    // Randomized traffic with idle gaps
    for (int n = 0; n < 1200; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        apply(rnd_ins(1'b0));
        step();
      end else begin
        run(rnd_ins(1'b1));
      end
    end
    for (int k = 0; k < 4; k++) begin
      apply(rnd_ins(1'b0));
      step();
    end

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
